// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one result bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output Ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q, done_q;
  logic             d_bit, br_d;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  // Full-subtractor cell on the current LSBs
  assign d_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_d  = (~a_sh_q[0] & b_sh_q[0])
               | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q <= A;
            b_sh_q <= B;
            br_q   <= Bin;
            res_q  <= '0;
            cnt_q  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= {d_bit, res_q[WIDTH-1:1]};
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
        end
        S_DONE: begin
          diff_q <= res_q;
          bout_q <= br_q;
          done_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_q <= (a_msb_q ^ b_msb_q) & (res_q[WIDTH-1] ^ a_msb_q);
`endif
        end
        default: ;
      endcase
    end
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign done = done_q;
`ifdef SERIAL_SUB_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): vector table, corner sequences,
// exhaustive sweep and randomized ops against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       Bin = 1'b0;
  logic [3:0] Diff;
  logic       Bout, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic       Ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .Diff (Diff),
    .Bout (Bout),
    .busy (busy),
    .done (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf  (Ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow is bit 4
  function automatic logic [4:0] model(input logic [3:0] a, b,
                                       input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return 5'(r & 31);
  endfunction

  function automatic logic ovf_model(input logic [3:0] a, b, d);
    return (a[3] != b[3]) && (d[3] != a[3]);
  endfunction

  task automatic run_op(input logic [3:0] a, b, input logic bin,
                        input bit scr, output logic [3:0] d,
                        output logic bo, output logic ov);
    int lat, bz, chg;
    bit seen;
    logic [3:0] hold;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    hold = Diff;
    @(negedge clk);
    start = 1'b0;
    bz = int'(busy);
    chg = 0; seen = 0; lat = 0;
    if (scr) begin
      A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
    end
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
      else begin
        bz += int'(busy);
        if (Diff !== hold) chg++;
      end
      if (scr) begin
        A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
      end
    end
    chk("done_seen", 32'(seen), 1);
    chk("latency", 32'(lat), 5);
    chk("busy_cycles", 32'(bz), 4);
    chk("hold_in_run", 32'(chg), 0);
    d = Diff;
    bo = Bout;
`ifdef SERIAL_SUB_OVF_EN
    ov = Ovf;
`else
    ov = 1'b0;
`endif
    @(negedge clk);
    chk("done_width", 32'(done), 0);
  endtask

  task automatic check_res(input string nm, input logic [3:0] a, b,
                           input logic bin, input logic [3:0] d,
                           input logic bo, input logic ov);
    logic [4:0] e;
    e = model(a, b, bin);
    chk(nm, {27'd0, bo, d}, {27'd0, e});
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, 32'(ov), 32'(ovf_model(a, b, e[3:0])));
`else
    if (ov !== 1'b0) chk({nm, "_ovf_absent"}, 32'(ov), 0);
`endif
  endtask

  initial begin
    vec_t tbl[8];
    logic [3:0] d;
    logic bo, ov;
    int pulses;
    logic [3:0] seen_diff;
    logic seen_bout;

    tbl[0] = '{4'd9,  4'd3,  1'b0, 4'b0110, 1'b0};
    tbl[1] = '{4'd3,  4'd9,  1'b0, 4'b1010, 1'b1};
    tbl[2] = '{4'd5,  4'd5,  1'b1, 4'b1111, 1'b1};
    tbl[3] = '{4'd7,  4'd8,  1'b0, 4'b1111, 1'b1};
    tbl[4] = '{4'd12, 4'd4,  1'b0, 4'b1000, 1'b0};
    tbl[5] = '{4'd0,  4'd15, 1'b1, 4'b0000, 1'b1};
    tbl[6] = '{4'd15, 4'd0,  1'b0, 4'b1111, 1'b0};
    tbl[7] = '{4'd0,  4'd0,  1'b1, 4'b1111, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_diff", 32'(Diff), 0);
    chk("rst_bout", 32'(Bout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0, d, bo, ov);
      chk($sformatf("tbl%0d_diff", i), 32'(d), 32'(tbl[i].diff));
      chk($sformatf("tbl%0d_bout", i), 32'(bo), 32'(tbl[i].bout));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), 32'(ov),
          32'(ovf_model(tbl[i].a, tbl[i].b, tbl[i].diff)));
`endif
    end

    // Second start while running must be ignored
    @(negedge clk);
    A = 4'd12; B = 4'd4; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    A = 4'd1; B = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; seen_diff = '0; seen_bout = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        seen_diff = Diff;
        seen_bout = Bout;
      end
    end
    chk("ign_pulses", 32'(pulses), 1);
    chk("ign_diff", 32'(seen_diff), 32'd8);
    chk("ign_bout", 32'(seen_bout), 0);

    // Reset during the second RUN cycle aborts the op
    @(negedge clk);
    A = 4'd15; B = 4'd1; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_diff", 32'(Diff), 0);
    chk("abort_bout", 32'(Bout), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pulses += int'(done) + int'(busy);
    end
    chk("abort_quiet", 32'(pulses), 0);
    run_op(4'd2, 4'd1, 1'b0, 1'b0, d, bo, ov);
    chk("after_abort_diff", 32'(d), 32'd1);
    chk("after_abort_bout", 32'(bo), 0);

    $monitor("mon t=%0t done=%b A=%h B=%h Bin=%b Diff=%h Bout=%b",
             $time, done, A, B, Bin, Diff, Bout);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          run_op(4'(a), 4'(b), 1'(c), 1'b0, d, bo, ov);
          check_res($sformatf("ex_%0d_%0d_%0d", a, b, c),
                    4'(a), 4'(b), 1'(c), d, bo, ov);
        end
    $monitoroff;

    for (int r = 0; r < 40; r++) begin
      logic [3:0] ra, rb;
      logic rc;
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, 1'b1, d, bo, ov);
      check_res($sformatf("rnd%0d", r), ra, rb, rc, d, bo, ov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
